// File: rtl/data_memory_pkg.sv
// data_memory shared types and sizing.
// Widths, MMIO addresses and FSM/source encodings.
package data_memory_pkg;

  localparam int DMEM_ADDR_W     = 16;
  localparam int DMEM_W_OPR      = 32;
  localparam int DMEM_DEPTH_LOG2 = 10;

  localparam logic [15:0] MMIO_PUTC_ADDR  = 16'hFFFF;
  localparam logic [15:0] MMIO_CYCLE_ADDR = 16'hFFFE;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } dmem_state_t;

  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_CYC  = 2'd2
  } dmem_src_t;

endpackage

// File: rtl/data_memory_ram.sv
// Single-port RAM with write enable and registered read.
// A write also loads the read register (write-through).
module data_memory_ram #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_memory.sv
// Data memory for the execute-stage load/store path.
// Optional console/cycle-counter MMIO under DATA_MEMORY_MMIO_EN.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int ADDR       = DMEM_ADDR_W,
  parameter int W_OPR      = DMEM_W_OPR,
  parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic [ADDR-1:0]  addr_i,
  input  logic             write_i,
  input  logic [W_OPR-1:0] data_i,
  output logic [W_OPR-1:0] data_o,
  output logic             busy_o,
  output logic             putc_v_o,
  output logic [7:0]       putc_data_o
);

  dmem_state_t state_q, state_d;
  dmem_src_t   src_q, src_d;

  logic [DEPTH_LOG2-1:0] cnt_q;
  logic                  in_range;
  logic                  accept;
  logic                  is_cyc;
  logic [W_OPR-1:0]      cyc_snap;

  logic                  ram_en;
  logic                  ram_we;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [W_OPR-1:0]      ram_wdata;
  logic [W_OPR-1:0]      ram_rdata;

  assign in_range = (addr_i[ADDR-1:DEPTH_LOG2] == '0);
  assign accept   = (state_q == ST_READY) && !stall_i;
  assign busy_o   = (state_q == ST_CLEAR);

`ifdef DATA_MEMORY_MMIO_EN
  logic [W_OPR-1:0] cyc_q;
  logic [W_OPR-1:0] cyc_snap_q;
  logic             is_putc;
  logic             putc_v_q;
  logic [7:0]       putc_d_q;

  assign is_putc = write_i && (addr_i == ADDR'(MMIO_PUTC_ADDR));
  assign is_cyc  = !write_i && (addr_i == ADDR'(MMIO_CYCLE_ADDR));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q      <= '0;
      cyc_snap_q <= '0;
      putc_v_q   <= 1'b0;
      putc_d_q   <= '0;
    end else begin
      cyc_q    <= cyc_q + 1'b1;
      putc_v_q <= accept && is_putc;
      if (accept && is_cyc)
        cyc_snap_q <= cyc_q;
      if (accept && is_putc)
        putc_d_q <= data_i[7:0];
    end
  end

  assign cyc_snap    = cyc_snap_q;
  assign putc_v_o    = putc_v_q;
  assign putc_data_o = putc_d_q;
`else
  assign is_cyc      = 1'b0;
  assign cyc_snap    = '0;
  assign putc_v_o    = 1'b0;
  assign putc_data_o = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_CLEAR;
      src_q   <= SRC_ZERO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      if (state_q == ST_CLEAR)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // Clear sweep owns the RAM port until READY; stalls don't pause it.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = addr_i[DEPTH_LOG2-1:0];
    ram_wdata = data_i;
    unique case (state_q)
      ST_CLEAR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = cnt_q;
        ram_wdata = '0;
        src_d     = SRC_ZERO;
        if (cnt_q == '1)
          state_d = ST_READY;
      end
      ST_READY: begin
        if (!stall_i) begin
          if (in_range) begin
            ram_en = 1'b1;
            ram_we = write_i;
            src_d  = SRC_RAM;
          end else if (is_cyc) begin
            src_d = SRC_CYC;
          end else begin
            src_d = SRC_ZERO;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    data_o = '0;
    unique case (src_q)
      SRC_RAM:  data_o = ram_rdata;
      SRC_CYC:  data_o = cyc_snap;
      default:  data_o = '0;
    endcase
  end

  data_memory_ram #(
    .AW (DEPTH_LOG2),
    .DW (W_OPR)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory.
// Behavioural model plus directed literal checks.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_i = 1'b0;
  logic [15:0] addr_i = '0;
  logic        write_i = 1'b0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        busy_o;
  logic        putc_v_o;
  logic [7:0]  putc_data_o;

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  data_memory dut (
    .clk         (clk),
    .reset       (reset),
    .stall_i     (stall_i),
    .addr_i      (addr_i),
    .write_i     (write_i),
    .data_i      (data_i),
    .data_o      (data_o),
    .busy_o      (busy_o),
    .putc_v_o    (putc_v_o),
    .putc_data_o (putc_data_o)
  );

  // Model state
  logic [31:0] mem_m [1024];
  int          clear_left = 1024;
  logic [31:0] m_data = '0;
  logic        m_pv = 1'b0;
  logic [7:0]  m_pd = '0;
  logic [31:0] m_cyc = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      clear_left <= 1024;
      m_data     <= '0;
      m_pv       <= 1'b0;
      m_pd       <= '0;
      m_cyc      <= '0;
    end else begin
      m_cyc <= m_cyc + 1;
      m_pv  <= 1'b0;
      if (clear_left > 0) begin
        clear_left <= clear_left - 1;
        m_data     <= '0;
        if (clear_left == 1)
          foreach (mem_m[i]) mem_m[i] <= '0;
      end else if (!stall_i) begin
        if (int'(addr_i) < 1024) begin
          if (write_i) begin
            mem_m[addr_i[9:0]] <= data_i;
            m_data             <= data_i;
          end else begin
            m_data <= mem_m[addr_i[9:0]];
          end
        end else begin
          m_data <= '0;
`ifdef DATA_MEMORY_MMIO_EN
          if (write_i && addr_i == 16'hFFFF) begin
            m_pv <= 1'b1;
            m_pd <= data_i[7:0];
          end
          if (!write_i && addr_i == 16'hFFFE)
            m_data <= m_cyc;
`endif
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy_o}, {31'd0, clear_left != 0});
      chk("data", data_o, m_data);
      chk("putc_v", {31'd0, putc_v_o}, {31'd0, m_pv});
      chk("putc_d", {24'd0, putc_data_o}, {24'd0, m_pd});
    end
  end

  task automatic req(input logic [15:0] a, input logic w,
                     input logic [31:0] d, input logic s);
    addr_i  = a;
    write_i = w;
    data_i  = d;
    stall_i = s;
    @(negedge clk);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    reset  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy_o}, 32'd1);
    chk("rst_data", data_o, 32'd0);
    chk("rst_putc_v", {31'd0, putc_v_o}, 32'd0);
    chk("rst_putc_d", {24'd0, putc_data_o}, 32'd0);
    reset  = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic busy_len();
    int n = 0;
    while (busy_o === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("busy_len", n, 32'd1024);
  endtask

  logic [31:0] c1;

  initial begin
    #2;
    @(negedge clk);
    do_reset();
    busy_len();

    req(16'd5, 1'b0, 32'h0, 1'b0);
    chk("first_load", data_o, 32'h0);

    req(16'd3, 1'b1, 32'hDEADBEEF, 1'b0);
    chk("wr_through", data_o, 32'hDEADBEEF);
    req(16'd3, 1'b0, 32'h0, 1'b0);
    chk("rd_after_wr", data_o, 32'hDEADBEEF);

    repeat (3) begin
      req(16'd7, 1'b1, 32'h12345678, 1'b1);
      chk("stall_hold", data_o, 32'hDEADBEEF);
    end
    req(16'd7, 1'b1, 32'h12345678, 1'b0);
    chk("stall_commit", data_o, 32'h12345678);

    req(16'd9, 1'b1, 32'hCAFEF00D, 1'b1);
    req(16'd9, 1'b1, 32'hCAFEF00D, 1'b1);
    req(16'd9, 1'b0, 32'h0, 1'b0);
    chk("stall_nowrite", data_o, 32'h0);

    req(16'd0, 1'b1, 32'hAAAA5555, 1'b0);
    req(16'h0800, 1'b1, 32'h55, 1'b0);
    chk("oor_wr", data_o, 32'h0);
    req(16'h0800, 1'b0, 32'h0, 1'b0);
    chk("oor_rd", data_o, 32'h0);
    req(16'h0400, 1'b1, 32'h77, 1'b0);
    req(16'd0, 1'b0, 32'h0, 1'b0);
    chk("alias_kept", data_o, 32'hAAAA5555);

    req(16'd1023, 1'b1, 32'hF00DF00D, 1'b0);
    req(16'd1023, 1'b0, 32'h0, 1'b0);
    chk("top_word", data_o, 32'hF00DF00D);

    for (int i = 0; i < 16; i++)
      req(16'((i * 67 + 11) % 1024), 1'b1, 32'hA0000000 + i * 1234567,
          1'b0);
    for (int i = 15; i >= 0; i--)
      req(16'((i * 67 + 11) % 1024), 1'b0, 32'h0, (i % 5) == 2);

`ifdef DATA_MEMORY_MMIO_EN
    req(16'hFFFF, 1'b1, 32'h00000041, 1'b0);
    chk("putc_pulse", {31'd0, putc_v_o}, 32'd1);
    chk("putc_byte", {24'd0, putc_data_o}, 32'h41);
    req(16'd0, 1'b0, 32'h0, 1'b0);
    chk("putc_end", {31'd0, putc_v_o}, 32'd0);
    req(16'd1023, 1'b0, 32'h0, 1'b0);
    chk("putc_noram", data_o, 32'hF00DF00D);
    req(16'hFFFE, 1'b0, 32'h0, 1'b0);
    c1 = data_o;
    repeat (9) req(16'd0, 1'b0, 32'h0, 1'b0);
    req(16'hFFFE, 1'b0, 32'h0, 1'b0);
    chk("cyc_delta", data_o - c1, 32'd10);
    req(16'hFFFF, 1'b0, 32'h0, 1'b0);
    chk("putc_rd", data_o, 32'h0);
`else
    req(16'hFFFF, 1'b1, 32'h00000041, 1'b0);
    chk("no_putc", {31'd0, putc_v_o}, 32'd0);
    req(16'hFFFE, 1'b0, 32'h0, 1'b0);
    chk("no_cyc", data_o, 32'h0);
`endif

    req(16'd3, 1'b1, 32'hFFFFFFFF, 1'b0);
    do_reset();
    repeat (500) @(negedge clk);
    do_reset();
    busy_len();
    req(16'd3, 1'b0, 32'h0, 1'b0);
    chk("cleared", data_o, 32'h0);
    req(16'd7, 1'b0, 32'h0, 1'b0);
    chk("cleared7", data_o, 32'h0);

    req(16'd0, 1'b0, 32'h0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
